// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the serial frame transmitter.
package frame_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_GAP
    } frame_tx_state_t;

    localparam logic [3:0] FRAME_TX_DEFAULT_PREAMBLE = 4'b1010;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/frame_tx_piso_shift.sv
// Parallel-load, MSB-first shift register feeding the payload phase of a frame.
module piso_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] sr;

    // Load wins over shift so a back-to-back word replaces any stale bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign msb = sr[DATA_W-1];

endmodule

// File: rtl/frame_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, then idle gap bits.
module frame_tx
    import frame_tx_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int PRE_W    = 4,
    parameter     PREAMBLE = FRAME_TX_DEFAULT_PREAMBLE,
    parameter int GAP      = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(max3(PRE_W, DATA_W, GAP) + 1);
    localparam logic [PRE_W-1:0] PRE_BITS = PRE_W'(PREAMBLE);

    if (DATA_W < 1 || PRE_W < 1 || GAP < 0 || $bits(PREAMBLE) != PRE_W) begin : g_param_check
        $error("frame_tx: illegal DATA_W/PRE_W/GAP/PREAMBLE combination");
    end

    frame_tx_state_t  state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             en;
    logic             accept;
    logic             last_pre, last_data, last_gap, final_cycle;
    logic             msb, shift;
    logic [PRE_W-1:0] pre_shifted;
    logic             dout_nxt, dout_valid_nxt, frame_done_nxt;

    assign last_pre    = (state == S_PRE)  && (cnt == CNT_W'(PRE_W - 1));
    assign last_data   = (state == S_DATA) && (cnt == CNT_W'(DATA_W - 1));
    assign last_gap    = (state == S_GAP)  && (cnt == CNT_W'(GAP - 1));
    assign final_cycle = (GAP == 0) ? last_data : last_gap;

    // Ready in idle and in the last cycle of a frame, gated until the first edge after reset.
    assign in_ready = en && ((state == S_IDLE) || final_cycle);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
            en    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            en    <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept) state_nxt = S_PRE;
            S_PRE:  if (last_pre) state_nxt = S_DATA;
            S_DATA: begin
                if (last_data) begin
                    if (GAP > 0)     state_nxt = S_GAP;
                    else if (accept) state_nxt = S_PRE;
                    else             state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (last_gap) begin
                    if (accept) state_nxt = S_PRE;
                    else        state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so the flops line up with state/cnt.
    always_comb begin
        cnt_nxt        = '0;
        dout_nxt       = 1'b0;
        dout_valid_nxt = 1'b0;
        frame_done_nxt = 1'b0;
        shift          = 1'b0;
        if (state_nxt == state && state != S_IDLE) begin
            cnt_nxt = cnt + 1'b1;
        end
        pre_shifted = PRE_BITS << cnt_nxt;
        if (state_nxt == S_PRE) begin
            dout_nxt       = pre_shifted[PRE_W-1];
            dout_valid_nxt = 1'b1;
        end else if (state_nxt == S_DATA) begin
            dout_nxt       = msb;
            dout_valid_nxt = 1'b1;
            shift          = 1'b1;
            frame_done_nxt = (cnt_nxt == CNT_W'(DATA_W - 1));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    piso_shift #(.DATA_W(DATA_W)) u_piso (
        .clk    (clk),
        .resetn (resetn),
        .load   (accept),
        .shift  (shift),
        .din    (in_data),
        .msb    (msb)
    );

endmodule
